riscv_mem_ctrl: RTL and testbench

- Sequences CPU load/store requests onto the word-wide data-memory/IO bridge port.
- Stores narrower than a word use read-modify-write, so SB/SH never corrupt neighbouring bytes.
- Loads get lane extraction plus sign/zero extension.
- Sits between the execute/memory stage and riscv_io_bridge; one request is in flight at a time.

---
 rtl/riscv_mem_ctrl_pkg.sv | 29 ++
 rtl/riscv_mem_ctrl_lane.sv | 39 +++
 rtl/riscv_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_riscv_mem_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_ctrl_pkg.sv
// riscv_mem_ctrl_pkg: shared access-size codes, controller state encoding
// and the alignment rule used by the load/store sequencer.
package riscv_mem_ctrl_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        MEMC_IDLE = 2'd0,
        MEMC_RD   = 2'd1,
        MEMC_CAP  = 2'd2,
        MEMC_WR   = 2'd3
    } memc_state_e;

    // Size 11 is never legal; halves need even, words need 4-byte alignment.
    function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (size == MEM_SIZE_B): bad = 1'b0;
            (size == MEM_SIZE_H): bad = off[0];
            (size == MEM_SIZE_W): bad = (off != 2'b00);
            default:              bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/riscv_mem_ctrl_lane.sv
// riscv_mem_lane: combinational lane logic for the memory controller.
// Ports: rdata_i/wdata_i words, size_i, uns_i, off_i -> ext_o (extended load), merged_o (RMW word).
module riscv_mem_lane
    import riscv_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = rdata_i[{off_i, 3'b000} +: 8];
        half_v   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ext_o    = rdata_i;
        merged_o = rdata_i;
        unique case (1'b1)
            (size_i == MEM_SIZE_B): begin
                ext_o = {{24{~uns_i & byte_v[7]}}, byte_v};
                merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            (size_i == MEM_SIZE_H): begin
                ext_o = {{16{~uns_i & half_v[15]}}, half_v};
                merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                ext_o    = rdata_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/riscv_mem_ctrl.sv
// riscv_mem_ctrl: sequences CPU loads/stores onto the word-wide bridge port,
// using read-modify-write for SB/SH. Ports: req_* (CPU side), resp_* (completion), mem_* (bridge).
module riscv_mem_ctrl
    import riscv_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    memc_state_e       state_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              rerr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;
    logic              mwe_q;

    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic [31:0]       ext;
    logic [31:0]       merged;

    riscv_mem_lane u_lane (
        .rdata_i  (mem_rdata),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .off_i    (off_q),
        .ext_o    (ext),
        .merged_o (merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MEMC_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwe_q    <= 1'b0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            mwe_q    <= 1'b0;
            unique case (state_q)
                MEMC_IDLE: begin
                    if (req_valid) begin
                        off_q   <= req_addr[1:0];
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            // Rejected without touching the bridge; stay ready.
                            rvalid_q <= 1'b1;
                            rerr_q   <= 1'b1;
                            rdata_q  <= '0;
                        end else if (req_we && req_size == MEM_SIZE_W) begin
                            state_q  <= MEMC_WR;
                            ready_q  <= 1'b0;
                            maddr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mwdata_q <= req_wdata;
                            mwe_q    <= 1'b1;
                        end else begin
                            state_q  <= MEMC_RD;
                            ready_q  <= 1'b0;
                            maddr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                MEMC_RD: begin
                    state_q <= MEMC_CAP;
                end
                MEMC_CAP: begin
                    if (we_q) begin
                        state_q  <= MEMC_WR;
                        mwdata_q <= merged;
                        mwe_q    <= 1'b1;
                    end else begin
                        state_q  <= MEMC_IDLE;
                        ready_q  <= 1'b1;
                        rvalid_q <= 1'b1;
                        rdata_q  <= ext;
                    end
                end
                MEMC_WR: begin
                    state_q  <= MEMC_IDLE;
                    ready_q  <= 1'b1;
                    rvalid_q <= 1'b1;
                    rdata_q  <= '0;
                end
                default: begin
                    state_q <= MEMC_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_err   = rerr_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;
    assign mem_we     = mwe_q;

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// tb_riscv_mem_ctrl: scoreboard bench for riscv_mem_ctrl with a
// word-wide memory model that returns read data one cycle after the address.
module tb_riscv_mem_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    riscv_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    logic [31:0] mem [logic [31:0]];
    int          cyc = 0;
    int          acc_q[$];
    int          acc_log[$];
    resp_t       exp_q[$];
    resp_t       obs_q[$];
    int          wr_cnt = 0;
    int          we_run_bad = 0;
    int          ready_low = 0;
    logic        we_prev = 1'b0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    int          pass = 0;
    int          total = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= rd(mem_addr);
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_we && we_prev) we_run_bad++;
        we_prev = mem_we;
        if (rst && req_valid && req_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
        cyc++;
    end

    always @(negedge clk) begin
        resp_t o;
        if (!rst) begin
            acc_q.delete();
        end else if (resp_valid) begin
            o.rdata = resp_rdata;
            o.err   = resp_err;
            o.lat   = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
            obs_q.push_back(o);
        end
        if (!req_ready) ready_low++;
    end

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er,
                         input logic ee, input int el, input bit keep);
        resp_t e;
        e.rdata = er;
        e.err   = ee;
        e.lat   = el;
        exp_q.push_back(e);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        total++;
        if (!req_ready) $display("FAIL accept_wait addr=%h ready=%b want 1", a, req_ready);
        else pass++;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (obs_q.size() < exp_q.size()) begin
            $display("FAIL resp_wait got %0d responses want %0d", obs_q.size(), exp_q.size());
            exp_q.delete();
            obs_q.delete();
        end else pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000)
            $display("FAIL reset_ctrl got %b want 1000", {req_ready, resp_valid, resp_err, mem_we});
        else pass++;
        total++;
        if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", resp_rdata);
        else pass++;
        total++;
        if (mem_addr !== 32'h0) $display("FAIL reset_maddr got %h want 0", mem_addr);
        else pass++;
        total++;
        if (mem_wdata !== 32'h0) $display("FAIL reset_mwdata got %h want 0", mem_wdata);
        else pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store();
        resp_t e, o;
        int w0;
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata) $display("FAIL sw_rdata got %h want %h", o.rdata, e.rdata);
            else pass++;
            total++;
            if (o.err !== e.err) $display("FAIL sw_err got %b want %b", o.err, e.err);
            else pass++;
            total++;
            if (o.lat != e.lat) $display("FAIL sw_lat got %0d want %0d", o.lat, e.lat);
            else pass++;
        end
        total++;
        if (wr_cnt - w0 != 1) $display("FAIL sw_writes got %0d want 1", wr_cnt - w0);
        else pass++;
        total++;
        if (last_waddr !== 32'h10) $display("FAIL sw_waddr got %h want 00000010", last_waddr);
        else pass++;
        total++;
        if (last_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h want deadbeef", last_wdata);
        else pass++;
    endtask

    task automatic test_partial_store();
        resp_t e, o;
        int w0;
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 32'h0, 1'b0, 4, 1'b0);
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata) $display("FAIL sb_rdata got %h want %h", o.rdata, e.rdata);
            else pass++;
            total++;
            if (o.err !== e.err) $display("FAIL sb_err got %b want %b", o.err, e.err);
            else pass++;
            total++;
            if (o.lat != e.lat) $display("FAIL sb_lat got %0d want %0d", o.lat, e.lat);
            else pass++;
        end
        total++;
        if (wr_cnt - w0 != 1) $display("FAIL sb_writes got %0d want 1", wr_cnt - w0);
        else pass++;
        total++;
        if (last_waddr !== 32'h20) $display("FAIL sb_waddr got %h want 00000020", last_waddr);
        else pass++;
        total++;
        if (last_wdata !== 32'h11AA3344) $display("FAIL sb_wdata got %h want 11aa3344", last_wdata);
        else pass++;
        total++;
        if (we_run_bad != 0) $display("FAIL we_single got %0d long pulses want 0", we_run_bad);
        else pass++;
    endtask

    task automatic test_loads();
        resp_t e, o;
        issue(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'h0000007F, 1'b0, 3, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'h000000FF, 1'b0, 3, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF8000, 1'b0, 3, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h00008000, 1'b0, 3, 1'b0);
        issue(1'b0, 2'b10, 1'b1, 32'h30, 32'h0, 32'h8000FF7F, 1'b0, 3, 1'b0);
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata) $display("FAIL ld_rdata got %h want %h", o.rdata, e.rdata);
            else pass++;
            total++;
            if (o.err !== e.err) $display("FAIL ld_err got %b want %b", o.err, e.err);
            else pass++;
            total++;
            if (o.lat != e.lat) $display("FAIL ld_lat got %0d want %0d", o.lat, e.lat);
            else pass++;
        end
    endtask

    task automatic test_misaligned();
        resp_t e, o;
        int w0, r0;
        w0 = wr_cnt;
        r0 = ready_low;
        issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h23, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata) $display("FAIL mis_rdata got %h want %h", o.rdata, e.rdata);
            else pass++;
            total++;
            if (o.err !== e.err) $display("FAIL mis_err got %b want %b", o.err, e.err);
            else pass++;
            total++;
            if (o.lat != e.lat) $display("FAIL mis_lat got %0d want %0d", o.lat, e.lat);
            else pass++;
        end
        total++;
        if (wr_cnt != w0) $display("FAIL mis_writes got %0d want 0", wr_cnt - w0);
        else pass++;
        total++;
        if (ready_low != r0) $display("FAIL mis_ready got %0d low cycles want 0", ready_low - r0);
        else pass++;
    endtask

    task automatic test_reset_mid();
        resp_t e, o;
        int w0;
        w0 = wr_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h20, 32'h5555, 32'h0, 1'b0, 4, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000)
            $display("FAIL rmid_ctrl got %b want 1000", {req_ready, resp_valid, resp_err, mem_we});
        else pass++;
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0)
            $display("FAIL rmid_data got %h/%h/%h want 0", mem_addr, mem_wdata, resp_rdata);
        else pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (wr_cnt != w0) $display("FAIL rmid_writes got %0d want 0", wr_cnt - w0);
        else pass++;
        total++;
        if (obs_q.size() != 0) $display("FAIL rmid_resp got %0d want 0", obs_q.size());
        else pass++;
        exp_q.delete();
        obs_q.delete();
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 3, 1'b0);
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata) $display("FAIL rpost_rdata got %h want %h", o.rdata, e.rdata);
            else pass++;
            total++;
            if (o.lat != e.lat) $display("FAIL rpost_lat got %0d want %0d", o.lat, e.lat);
            else pass++;
        end
    endtask

    task automatic test_back_to_back();
        resp_t e, o;
        int n0;
        n0 = acc_log.size();
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0);
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.rdata !== e.rdata) $display("FAIL b2b_rdata got %h want %h", o.rdata, e.rdata);
            else pass++;
            total++;
            if (o.err !== e.err) $display("FAIL b2b_err got %b want %b", o.err, e.err);
            else pass++;
            total++;
            if (o.lat != e.lat) $display("FAIL b2b_lat got %0d want %0d", o.lat, e.lat);
            else pass++;
        end
        total++;
        if (acc_log.size() < n0 + 2)
            $display("FAIL b2b_accepts got %0d want 2", acc_log.size() - n0);
        else if (acc_log[n0+1] - acc_log[n0] != 2)
            $display("FAIL b2b_gap got %0d want 2", acc_log[n0+1] - acc_log[n0]);
        else pass++;
    endtask

    initial begin
        mem[32'h20] = 32'h11223344;
        mem[32'h30] = 32'h8000FF7F;
        test_reset();
        test_word_store();
        test_partial_store();
        test_loads();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
